// File: rtl/regfile_writeback.sv
// regfile_writeback: in-order write-back queue in front of the register file.
// Define WB_BYPASS_EN to build the pending-value bypass lookup.
module regfile_writeback #(
   parameter int DEPTH = 4
) (
   input  logic                       CLK,
   input  logic                       nRST,
   input  logic                       alu_valid,
   output logic                       alu_ready,
   input  logic [4:0]                 alu_sel,
   input  logic [31:0]                alu_dat,
   input  logic                       mem_valid,
   output logic                       mem_ready,
   input  logic [4:0]                 mem_sel,
   input  logic [31:0]                mem_dat,
   input  logic                       wb_stall,
   output logic                       WEN,
   output logic [4:0]                 wsel,
   output logic [31:0]                wdat,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count,
   input  logic [4:0]                 byp_sel,
   output logic                       byp_hit,
   output logic [31:0]                byp_dat
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [4:0]    sel_q [DEPTH];
   logic [31:0]   dat_q [DEPTH];
   logic [AW-1:0] head;
   logic [AW-1:0] tail;
   logic [CW-1:0] cnt;
   logic          full;
   logic          mem_fire;
   logic          alu_fire;
   logic          push;
   logic          pop;
   logic [4:0]    push_sel;
   logic [31:0]   push_dat;

   assign full      = (cnt == CW'(DEPTH));
   assign empty     = (cnt == '0);
   assign count     = cnt;
   assign mem_ready = !full;
   // Loads win any tie: the ALU is held off whenever a load is offered.
   assign alu_ready = !full && !mem_valid;
   assign mem_fire  = mem_valid && mem_ready;
   assign alu_fire  = alu_valid && alu_ready;

   always_comb begin
      push_sel = alu_sel;
      push_dat = alu_dat;
      if (mem_fire) begin
         push_sel = mem_sel;
         push_dat = mem_dat;
      end
   end

   // x0 writes complete the handshake but are never stored.
   assign push = (mem_fire || alu_fire) && (push_sel != '0);
   assign WEN  = !empty && !wb_stall;
   assign pop  = WEN;
   assign wsel = empty ? '0 : sel_q[head];
   assign wdat = empty ? '0 : dat_q[head];

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
      end else begin
         if (push) tail <= tail + AW'(1);
         if (pop)  head <= head + AW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (push) begin
         sel_q[tail] <= push_sel;
         dat_q[tail] <= push_dat;
      end
   end

`ifdef WB_BYPASS_EN
   // Walk oldest to youngest so the last match is the newest value.
   always_comb begin
      byp_hit = 1'b0;
      byp_dat = '0;
      for (int i = 0; i < DEPTH; i++) begin
         if (CW'(i) < cnt && byp_sel != '0 &&
             sel_q[head + AW'(i)] == byp_sel) begin
            byp_hit = 1'b1;
            byp_dat = dat_q[head + AW'(i)];
         end
      end
   end
`else
   logic byp_unused;
   assign byp_unused = ^byp_sel;
   assign byp_hit    = 1'b0;
   assign byp_dat    = '0;
`endif

endmodule

// File: tb/tb_regfile_writeback.sv
// tb_regfile_writeback: directed checks of the write-back queue.
// Runs the bypass scenario against whichever WB_BYPASS_EN build is compiled.
module tb_regfile_writeback;

   logic        CLK;
   logic        nRST;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_sel;
   logic [31:0] alu_dat;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_sel;
   logic [31:0] mem_dat;
   logic        wb_stall;
   logic        WEN;
   logic [4:0]  wsel;
   logic [31:0] wdat;
   logic        empty;
   logic [2:0]  count;
   logic [4:0]  byp_sel;
   logic        byp_hit;
   logic [31:0] byp_dat;

   int n_checks = 0;
   int n_fail   = 0;

   regfile_writeback #(.DEPTH(4)) dut (
      .CLK(CLK), .nRST(nRST),
      .alu_valid(alu_valid), .alu_ready(alu_ready),
      .alu_sel(alu_sel), .alu_dat(alu_dat),
      .mem_valid(mem_valid), .mem_ready(mem_ready),
      .mem_sel(mem_sel), .mem_dat(mem_dat),
      .wb_stall(wb_stall),
      .WEN(WEN), .wsel(wsel), .wdat(wdat),
      .empty(empty), .count(count),
      .byp_sel(byp_sel), .byp_hit(byp_hit), .byp_dat(byp_dat)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic tick;
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset;
      #3;
      n_checks++;
      if (empty !== 1'b1) begin
         n_fail++; $display("FAIL reset_empty: got %b want 1", empty);
      end
      n_checks++;
      if (count !== 3'd0) begin
         n_fail++; $display("FAIL reset_count: got %0d want 0", count);
      end
      n_checks++;
      if ({WEN, wsel, wdat} !== 38'd0) begin
         n_fail++;
         $display("FAIL reset_wport: got %b/%h/%h want 0", WEN, wsel, wdat);
      end
      n_checks++;
      if (byp_hit !== 1'b0) begin
         n_fail++; $display("FAIL reset_byp: got %b want 0", byp_hit);
      end
      @(negedge CLK);
      nRST = 1'b1;
      tick();
      n_checks++;
      if ({alu_ready, mem_ready} !== 2'b11) begin
         n_fail++;
         $display("FAIL post_reset_ready: got %b%b want 11",
                  alu_ready, mem_ready);
      end
   endtask

   task automatic test_alu_push;
      alu_valid = 1'b1; alu_sel = 5'd5; alu_dat = 32'hDEADBEEF;
      #1;
      n_checks++;
      if (alu_ready !== 1'b1 || WEN !== 1'b0) begin
         n_fail++;
         $display("FAIL alu_accept: ready=%b wen=%b want 1/0", alu_ready, WEN);
      end
      tick();
      alu_valid = 1'b0;
      #1;
      n_checks++;
      if (WEN !== 1'b1 || wsel !== 5'd5 || wdat !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL alu_write: got %b/%0d/%h want 1/5/deadbeef",
                  WEN, wsel, wdat);
      end
      tick();
      n_checks++;
      if (empty !== 1'b1 || WEN !== 1'b0 || wsel !== 5'd0) begin
         n_fail++;
         $display("FAIL alu_drained: empty=%b wen=%b wsel=%0d want 1/0/0",
                  empty, WEN, wsel);
      end
   endtask

   task automatic test_priority;
      mem_valid = 1'b1; mem_sel = 5'd3; mem_dat = 32'h11;
      alu_valid = 1'b1; alu_sel = 5'd4; alu_dat = 32'h22;
      #1;
      n_checks++;
      if ({mem_ready, alu_ready} !== 2'b10) begin
         n_fail++;
         $display("FAIL prio_ready: got mem=%b alu=%b want 1/0",
                  mem_ready, alu_ready);
      end
      tick();
      mem_valid = 1'b0;
      #1;
      n_checks++;
      if (WEN !== 1'b1 || wsel !== 5'd3 || wdat !== 32'h11 ||
          alu_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL prio_first: got %b/%0d/%h ar=%b want 1/3/11 ar=1",
                  WEN, wsel, wdat, alu_ready);
      end
      tick();
      alu_valid = 1'b0;
      #1;
      n_checks++;
      if (WEN !== 1'b1 || wsel !== 5'd4 || wdat !== 32'h22 ||
          count !== 3'd1) begin
         n_fail++;
         $display("FAIL prio_second: got %b/%0d/%h c=%0d want 1/4/22 c=1",
                  WEN, wsel, wdat, count);
      end
      tick();
      n_checks++;
      if (empty !== 1'b1) begin
         n_fail++; $display("FAIL prio_drained: got empty=%b want 1", empty);
      end
   endtask

   task automatic test_stall;
      wb_stall = 1'b1;
      for (int i = 0; i < 5; i++) begin
         alu_valid = 1'b1;
         alu_sel   = 5'(10 + i);
         alu_dat   = 32'h100 + 32'(i);
         #1;
         n_checks++;
         if (alu_ready !== (i < 4)) begin
            n_fail++;
            $display("FAIL stall_fill_ready[%0d]: got %b want %b",
                     i, alu_ready, (i < 4));
         end
         tick();
      end
      alu_valid = 1'b0;
      #1;
      n_checks++;
      if (count !== 3'd4 || alu_ready !== 1'b0 || mem_ready !== 1'b0 ||
          WEN !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_full: c=%0d ar=%b mr=%b wen=%b want 4/0/0/0",
                  count, alu_ready, mem_ready, WEN);
      end
      wb_stall = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_checks++;
         if (WEN !== 1'b1 || wsel !== 5'(10 + k) ||
             wdat !== 32'h100 + 32'(k)) begin
            n_fail++;
            $display("FAIL stall_drain[%0d]: got %b/%0d/%h want 1/%0d/%h",
                     k, WEN, wsel, wdat, 10 + k, 32'h100 + 32'(k));
         end
         if (k < 2) begin
            n_checks++;
            if (mem_ready !== (k == 1)) begin
               n_fail++;
               $display("FAIL stall_ready[%0d]: got %b want %b",
                        k, mem_ready, (k == 1));
            end
         end
         tick();
      end
      n_checks++;
      if (empty !== 1'b1 || WEN !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_drained: empty=%b wen=%b want 1/0", empty, WEN);
      end
   endtask

   task automatic test_sel_zero;
      alu_valid = 1'b1; alu_sel = 5'd0; alu_dat = 32'h55;
      #1;
      n_checks++;
      if (alu_ready !== 1'b1) begin
         n_fail++; $display("FAIL zero_alu_ready: got %b want 1", alu_ready);
      end
      tick();
      alu_valid = 1'b0;
      mem_valid = 1'b1; mem_sel = 5'd0; mem_dat = 32'h66;
      #1;
      n_checks++;
      if (count !== 3'd0 || WEN !== 1'b0 || mem_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL zero_alu_store: c=%0d wen=%b mr=%b want 0/0/1",
                  count, WEN, mem_ready);
      end
      tick();
      mem_valid = 1'b0;
      #1;
      n_checks++;
      if (count !== 3'd0 || WEN !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_mem_store: c=%0d wen=%b want 0/0", count, WEN);
      end
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 4; i++) begin
         alu_valid = (i < 3);
         alu_sel   = 5'(20 + i);
         alu_dat   = 32'hA000 + 32'(i);
         #1;
         if (i > 0) begin
            n_checks++;
            if (WEN !== 1'b1 || wsel !== 5'(19 + i) ||
                wdat !== 32'hA000 + 32'(i - 1) || count !== 3'd1) begin
               n_fail++;
               $display("FAIL b2b[%0d]: got %b/%0d/%h c=%0d want 1/%0d c=1",
                        i, WEN, wsel, wdat, count, 19 + i);
            end
         end
         tick();
      end
      n_checks++;
      if (empty !== 1'b1) begin
         n_fail++; $display("FAIL b2b_drained: got empty=%b want 1", empty);
      end
   endtask

   task automatic test_bypass;
      logic exp_on;
`ifdef WB_BYPASS_EN
      exp_on = 1'b1;
`else
      exp_on = 1'b0;
`endif
      wb_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1'b1;
         alu_sel   = (i == 2) ? 5'd8 : 5'd7;
         alu_dat   = 32'hA + 32'(i);
         tick();
      end
      alu_valid = 1'b0;
      byp_sel = 5'd7;
      #1;
      n_checks++;
      if (byp_hit !== exp_on || byp_dat !== (exp_on ? 32'hB : 32'h0)) begin
         n_fail++;
         $display("FAIL byp_youngest: got %b/%h want %b/%h", byp_hit,
                  byp_dat, exp_on, exp_on ? 32'hB : 32'h0);
      end
      byp_sel = 5'd8;
      #1;
      n_checks++;
      if (byp_hit !== exp_on || byp_dat !== (exp_on ? 32'hC : 32'h0)) begin
         n_fail++;
         $display("FAIL byp_sel8: got %b/%h want %b", byp_hit, byp_dat,
                  exp_on);
      end
      byp_sel = 5'd9;
      #1;
      n_checks++;
      if (byp_hit !== 1'b0 || byp_dat !== 32'h0) begin
         n_fail++;
         $display("FAIL byp_miss: got %b/%h want 0/0", byp_hit, byp_dat);
      end
      byp_sel = 5'd0;
      #1;
      n_checks++;
      if (byp_hit !== 1'b0 || byp_dat !== 32'h0) begin
         n_fail++;
         $display("FAIL byp_x0: got %b/%h want 0/0", byp_hit, byp_dat);
      end
      wb_stall = 1'b0;
      byp_sel  = 5'd7;
      tick();
      tick();
      n_checks++;
      if (byp_hit !== 1'b0 || wsel !== 5'd8) begin
         n_fail++;
         $display("FAIL byp_after_pop: hit=%b wsel=%0d want 0/8",
                  byp_hit, wsel);
      end
      byp_sel = 5'd8;
      #1;
      n_checks++;
      if (byp_hit !== exp_on || byp_dat !== (exp_on ? 32'hC : 32'h0)) begin
         n_fail++;
         $display("FAIL byp_head_pop: got %b/%h want %b", byp_hit, byp_dat,
                  exp_on);
      end
      byp_sel = 5'd0;
      tick();
   endtask

   task automatic test_reset_mid;
      wb_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         alu_valid = 1'b1;
         alu_sel   = 5'(1 + i);
         alu_dat   = 32'hF0 + 32'(i);
         tick();
      end
      alu_valid = 1'b0;
      #1;
      n_checks++;
      if (count !== 3'd3) begin
         n_fail++; $display("FAIL mid_fill: got count=%0d want 3", count);
      end
      #2;
      nRST = 1'b0;
      wb_stall = 1'b0;
      #1;
      n_checks++;
      if (WEN !== 1'b0 || count !== 3'd0 || empty !== 1'b1 ||
          wsel !== 5'd0) begin
         n_fail++;
         $display("FAIL mid_async: wen=%b c=%0d e=%b ws=%0d want 0/0/1/0",
                  WEN, count, empty, wsel);
      end
      tick();
      @(negedge CLK);
      nRST = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++;
         if (WEN !== 1'b0 || empty !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_after[%0d]: wen=%b empty=%b want 0/1",
                     i, WEN, empty);
         end
      end
   endtask

   initial begin
      nRST = 1'b0;
      alu_valid = 1'b0; alu_sel = '0; alu_dat = '0;
      mem_valid = 1'b0; mem_sel = '0; mem_dat = '0;
      wb_stall = 1'b0; byp_sel = '0;
      test_reset();
      test_alu_push();
      test_priority();
      test_stall();
      test_sel_zero();
      test_back_to_back();
      test_bypass();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/regfile_writeback.md
REGFILE_WRITEBACK -- requirements
Module: regfile_writeback

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning pending-write queue entries (power of 2, minimum 2).
REQ-002 SHALL have port CLK  input  1  the single rising-edge clock.
REQ-003 SHALL have port nRST  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have ports alu_valid, alu_ready  input/output  1 each  ALU result handshake.
REQ-005 SHALL have ports alu_sel, alu_dat  input  5, 32  ALU destination register and data.
REQ-006 SHALL have ports mem_valid, mem_ready  input/output  1 each  load result handshake.
REQ-007 SHALL have ports mem_sel, mem_dat  input  5, 32  load destination register and data.
REQ-008 SHALL have port wb_stall  input  1  inhibits register-file writes while high.
REQ-009 SHALL have ports WEN, wsel, wdat  output  1, 5, 32  register-file write port.
REQ-010 SHALL have ports empty, count  output  1, clog2(DEPTH)+1  queue status.
REQ-011 SHALL have ports byp_sel (input, 5), byp_hit (output, 1), byp_dat (output, 32)  pending-value lookup.

Function
REQ-012 SHALL hold pending writes in a DEPTH-entry circular FIFO of {sel, dat}, with head/tail pointers wrapping modulo DEPTH.
REQ-013 SHALL drive mem_ready = !full, combinationally from registered state.
REQ-014 SHALL drive alu_ready = !full && !mem_valid, giving the load path fixed priority.
REQ-015 SHALL enqueue at most one entry per edge, taken from the handshake where valid && ready.
REQ-016 SHALL accept handshakes whose sel == 0 but store no entry and leave count unchanged.
REQ-017 SHALL drive WEN = !empty && !wb_stall, and wsel/wdat = head entry when !empty, else 0.
REQ-018 SHALL pop the head on every edge where WEN == 1.
REQ-019 SHALL deliver an accepted entry no earlier than the cycle after acceptance, so an entry accepted into an empty queue at edge N appears on WEN in cycle N+1.
REQ-020 SHALL, on simultaneous push and pop, update both pointers and leave count unchanged.
REQ-021 SHALL deassert ready while full even when a pop occurs in the same cycle.
REQ-022 SHALL preserve acceptance order, so the register file sees writes in handshake order.
REQ-023 SHALL, while wb_stall is high, hold queue contents and continue accepting entries until full.

Reset
REQ-024 SHALL, on nRST low, immediately clear the pointers and count, giving empty = 1, count = 0, WEN = 0, wsel = 0, wdat = 0 and byp_hit = 0.
REQ-025 SHALL discard all pending entries when reset asserts mid-operation; no partial write shall occur.
REQ-026 SHALL drive alu_ready and mem_ready high in the first cycle after reset release.

Configuration
REQ-027 SHALL compile the bypass lookup only when macro WB_BYPASS_EN is defined.
REQ-028 SHALL, with WB_BYPASS_EN defined, drive byp_hit = 1 when byp_sel != 0 and any valid entry has sel == byp_sel, with byp_dat = data of the youngest such entry; otherwise byp_hit = 0 and byp_dat = 0.
REQ-029 SHALL, with WB_BYPASS_EN defined, include the head entry being popped this cycle in the lookup.
REQ-030 SHALL, without WB_BYPASS_EN, tie byp_hit and byp_dat to 0, with the ports still present.

Verification
REQ-031 SHALL cover reset then alu push {sel=5, dat=0xDEADBEEF} -> next cycle WEN=1, wsel=5, wdat=0xDEADBEEF; following cycle empty=1.
REQ-032 SHALL cover alu_valid and mem_valid both high, mem {3, 0x11}, alu {4, 0x22} -> mem accepted first, alu_ready=0 that cycle; writes appear as reg3 then reg4.
REQ-033 SHALL cover wb_stall=1 with 5 pushes at DEPTH=4 -> count=4, both ready=0, WEN=0; release stall -> 4 writes in order, with ready restored the cycle after the first pop.
REQ-034 SHALL cover a push with sel=0 -> ready=1, count stays 0, WEN never asserts.
REQ-035 SHALL cover, with WB_BYPASS_EN defined under stall, queue {7, 0xA}, {7, 0xB} and byp_sel=7 -> byp_hit=1, byp_dat=0xB; byp_sel=0 -> byp_hit=0.
REQ-036 SHALL cover nRST low with 3 entries queued -> WEN=0 and count=0 asynchronously; no write observed after release.
